tx_byte_serializer: RTL

Transmit-side byte-to-bit buffer for the USB 2.0 full-speed device core. It accepts bytes from the protocol layer's packet assembler and stores them in a synchronous FIFO. It then shifts each byte out one bit per handshake to the PHY interface layer, MSB first, so a bit-accumulating receiver reproduces the original byte. A per-byte `last` flag marks the packet end, and the block reports it on the final bit.

---
 rtl/usb_fs_pkg.sv | 14 +
 rtl/tx_sync_fifo.sv | 70 +++++++
 rtl/tx_byte_serializer.sv | 105 ++++++++++
 3 files changed

// File: rtl/usb_fs_pkg.sv
// Shared types for the USB 2.0 full-speed device core.
// The transmit FIFO entry carries the packet-end flag alongside each data byte.
package usb_fs_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } tx_entry_t;

endpackage

// File: rtl/tx_sync_fifo.sv
// Synchronous show-ahead FIFO of transmit entries.
// The head entry is visible on rd_entry whenever the FIFO is not empty.
module tx_sync_fifo
    import usb_fs_pkg::*;
#(
    parameter int depth = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  tx_entry_t wr_entry,
    input  logic      pop,
    output tx_entry_t rd_entry,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] DEPTH_C = AW'(depth) == '0 ? {1'b1, {AW{1'b0}}} : (AW+1)'(depth);

    tx_entry_t     mem_q [depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en;
    logic          rd_en;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign rd_entry = mem_q[rd_ptr_q];

    // Pointers wrap naturally because depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: rtl/tx_byte_serializer.sv
// Transmit byte-to-bit buffer: FIFO of bytes from the packet assembler, shifted
// MSB first to the PHY layer with a per-bit valid/ready handshake.
module tx_byte_serializer
    import usb_fs_pkg::*;
#(
    parameter int buffer_width = 8,
    parameter int buffer_depth = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [buffer_width-1:0] byte_in,
    input  logic                    byte_last,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic                    bit_last,
    input  logic                    phy_ready,
    output logic                    full,
    output logic                    empty,
    output logic                    idle
);

    tx_state_t         state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              last_q, last_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              fifo_pop;
    tx_entry_t         wr_entry;
    tx_entry_t         rd_entry;

    assign byte_ready = rst_n && !full;
    assign wr_entry   = '{last: byte_last, data: byte_in[BYTE_W-1:0]};

    tx_sync_fifo #(
        .depth (buffer_depth)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (byte_valid && byte_ready),
        .wr_entry (wr_entry),
        .pop      (fifo_pop),
        .rd_entry (rd_entry),
        .full     (full),
        .empty    (empty)
    );

    // A byte reloads straight from the FIFO head on its final bit so that
    // consecutive bytes leave with no idle cycle between them.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        bit_cnt_d = bit_cnt_q;
        fifo_pop  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!empty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = rd_entry.data;
                    last_d    = rd_entry.last;
                    bit_cnt_d = 3'd0;
                    state_d   = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (phy_ready) begin
                    shreg_d   = {shreg_q[BYTE_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (!empty) begin
                            fifo_pop = 1'b1;
                            shreg_d  = rd_entry.data;
                            last_d   = rd_entry.last;
                        end else begin
                            last_d  = 1'b0;
                            state_d = TX_IDLE;
                        end
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            shreg_q   <= '0;
            last_q    <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_valid = (state_q == TX_SHIFT);
    assign bit_out   = bit_valid && shreg_q[BYTE_W-1];
    assign bit_last  = bit_valid && last_q && (bit_cnt_q == 3'd7);
    assign idle      = (state_q == TX_IDLE) && empty;

endmodule
